// File: rtl/dma_stride_copy_if.sv
// Avalon-MM bundle shared by the CSR slave and the SDRAM master port.
// The master modport issues commands, the slave modport answers them.
interface dma_stride_copy_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          waitrequest;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  modport master (
    input  waitrequest,
    input  readdata,
    input  readdatavalid,
    output address,
    output read,
    output write,
    output writedata
  );

  modport slave (
    output waitrequest,
    output readdata,
    output readdatavalid,
    input  address,
    input  read,
    input  write,
    input  writedata
  );
endinterface

// File: rtl/dma_stride_copy.sv
// Strided block copier: CSR slave for programming and status, and one
// pipelined Avalon-MM master that buffers read data in a small FIFO.
module dma_stride_copy #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 8,
  parameter bit BLOCKING   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  dma_stride_copy_if.slave  csr,
  dma_stride_copy_if.master mem,
  output logic              irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic          r_ack;
  logic [31:0]   r_rdata;
  logic          r_irq_en;
  logic          r_done;
  logic          r_aborted;
  logic [31:0]   r_dst;
  logic [31:0]   r_src;
  logic [31:0]   r_num;
  logic [31:0]   r_sstr;
  logic [31:0]   r_dstr;
  logic [31:0]   r_wdone;

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_rd_left;
  logic [31:0]   r_wr_left;
  logic          r_cmd_rd;
  logic          r_cmd_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [DW-1:0] r_fifo [FIFO_DEPTH];

  logic          w_busy;
  logic          w_req;
  logic          w_stall;
  logic          w_cwr;
  logic          w_ctrl_wr;
  logic          w_start;
  logic          w_abort;
  logic          w_set_done;
  logic          w_set_abt;
  logic          w_run;
  logic [31:0]   w_rmux;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_free;
  logic          w_iss_rd;
  logic          w_iss_wr;
  logic          w_push;
  logic [CW:0]   w_inflight;

  assign w_busy    = (r_state != S_IDLE);
  assign w_req     = csr.read | csr.write;
  assign w_stall   = BLOCKING && csr.read &&
                     (csr.address == 4'd0) && w_busy;
  assign w_cwr     = csr.write && r_ack;
  assign w_ctrl_wr = w_cwr && (csr.address == 4'd0);
  assign w_start   = w_ctrl_wr && csr.writedata[0] && !w_busy;
  assign w_abort   = w_ctrl_wr && csr.writedata[1] &&
                     (r_state == S_RUN);

  assign csr.waitrequest   = w_req & ~r_ack;
  assign csr.readdata      = r_rdata;
  assign csr.readdatavalid = 1'b0;
  assign irq               = r_done & r_irq_en;

  assign mem.read      = r_cmd_rd;
  assign mem.write     = r_cmd_wr;
  assign mem.address   = r_addr;
  assign mem.writedata = r_wdata;

  assign w_rd_acc = r_cmd_rd & ~mem.waitrequest;
  assign w_wr_acc = r_cmd_wr & ~mem.waitrequest;
  assign w_free   = ~(r_cmd_rd | r_cmd_wr) | ~mem.waitrequest;
  assign w_push   = mem.readdatavalid && (r_state == S_RUN);

  // A read being accepted now is not yet in r_outst; count it early.
  assign w_inflight = {1'b0, r_outst} + {1'b0, r_cnt} +
                      {{CW{1'b0}}, w_rd_acc};

  assign w_iss_wr = w_run && w_free && (r_cnt != '0);
  assign w_iss_rd = w_run && w_free && (r_cnt == '0) &&
                    (r_rd_left != 32'd0) &&
                    (w_inflight < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_set_done = 1'b0;
    w_set_abt  = 1'b0;
    w_run      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start && (r_num != 32'd0)) w_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_abort) begin
          w_nxt = S_FLUSH;
        end else if (r_wr_left == 32'd0) begin
          w_nxt      = S_IDLE;
          w_set_done = 1'b1;
        end else begin
          w_run = 1'b1;
        end
      end
      S_FLUSH: begin
        if (!r_cmd_rd && !r_cmd_wr && (r_outst == '0)) begin
          w_nxt     = S_IDLE;
          w_set_abt = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rmux = '0;
    unique case (csr.address)
      4'd0:    w_rmux = {29'd0, r_aborted, r_done, w_busy};
      4'd1:    w_rmux = r_dst;
      4'd2:    w_rmux = r_src;
      4'd3:    w_rmux = r_num;
      4'd4:    w_rmux = r_sstr;
      4'd5:    w_rmux = r_dstr;
      4'd6:    w_rmux = r_wdone;
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_dst     <= '0;
      r_src     <= '0;
      r_num     <= '0;
      r_sstr    <= '0;
      r_dstr    <= '0;
    end else begin
      r_ack <= w_req && !r_ack && !w_stall;
      if (csr.read && !r_ack && !w_stall) r_rdata <= w_rmux;
      if (w_cwr && !w_busy) begin
        unique case (csr.address)
          4'd1:    r_dst  <= csr.writedata;
          4'd2:    r_src  <= csr.writedata;
          4'd3:    r_num  <= csr.writedata;
          4'd4:    r_sstr <= csr.writedata;
          4'd5:    r_dstr <= csr.writedata;
          default: ;
        endcase
      end
      if (w_ctrl_wr) r_irq_en <= csr.writedata[2];
      if (w_ctrl_wr && csr.writedata[3]) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (w_set_done) r_done <= 1'b1;
      if (w_set_abt) r_aborted <= 1'b1;
      if (w_start) begin
        r_done    <= (r_num == 32'd0);
        r_aborted <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_left <= '0;
      r_wr_left <= '0;
      r_wdone   <= '0;
      r_cnt     <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
    end else if (w_start) begin
      r_rd_ptr  <= r_src[AW-1:0];
      r_wr_ptr  <= r_dst[AW-1:0];
      r_rd_left <= r_num;
      r_wr_left <= r_num;
      r_wdone   <= '0;
      r_cnt     <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
    end else begin
      if (w_iss_rd) begin
        r_rd_ptr  <= r_rd_ptr + r_sstr[AW-1:0];
        r_rd_left <= r_rd_left - 32'd1;
      end
      if (w_iss_wr) begin
        r_wr_ptr <= r_wr_ptr + r_dstr[AW-1:0];
        r_rp     <= r_rp + PW'(1);
      end
      if (w_wr_acc) begin
        r_wr_left <= r_wr_left - 32'd1;
        r_wdone   <= r_wdone + 32'd1;
      end
      if (w_push) r_wp <= r_wp + PW'(1);
      unique case ({w_push, w_iss_wr})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else if (w_push) begin
      r_fifo[r_wp] <= mem.readdata;
    end
  end

  // Command is held until accepted; a new one loads only when free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_rd <= 1'b0;
      r_cmd_wr <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_outst  <= '0;
    end else begin
      if (w_free) begin
        r_cmd_rd <= w_iss_rd;
        r_cmd_wr <= w_iss_wr;
        if (w_iss_rd) r_addr <= r_rd_ptr;
        if (w_iss_wr) begin
          r_addr  <= r_wr_ptr;
          r_wdata <= r_fifo[r_rp];
        end
      end
      unique case ({w_rd_acc, mem.readdatavalid})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_stride_copy.sv
// Directed bench for dma_stride_copy: CPU-side CSR tasks and a
// behavioural SDRAM with random stalls and fixed read latency.
module tb_dma_stride_copy;
  logic clk = 1'b0;
  logic rst_n;
  logic irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] wlog_a [$];
  logic [31:0] wlog_d [$];
  logic [31:0] rlog_a [$];

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;
  rd_t rq [$];

  int cyc       = 0;
  int outst     = 0;
  int max_outst = 0;
  int overlap   = 0;
  int strobes   = 0;
  bit inited    = 1'b0;
  bit rnd_wait  = 1'b0;
  int lat       = 1;

  dma_stride_copy_if #(.DW(32), .AW(4))  csr_if ();
  dma_stride_copy_if #(.DW(32), .AW(32)) mem_if ();

  dma_stride_copy #(
    .DW(32),
    .AW(32),
    .FIFO_DEPTH(8),
    .BLOCKING(1'b1)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .csr  (csr_if),
    .mem  (mem_if),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SDRAM model: decides accept at negedge for the command
  // the DUT will present at the following posedge.
  always @(negedge clk) begin : model
    rd_t e;
    if (!rst_n) begin
      if (!inited) begin
        for (int i = 0; i < 1024; i++)
          mem[i] = 32'hC0DE_0000 | 32'(i * 4);
        inited = 1'b1;
      end
      rq.delete();
      outst = 0;
      mem_if.waitrequest   = 1'b0;
      mem_if.readdatavalid = 1'b0;
      mem_if.readdata      = '0;
    end else begin
      cyc++;
      mem_if.readdatavalid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        mem_if.readdatavalid = 1'b1;
        mem_if.readdata      = rq[0].d;
        void'(rq.pop_front());
        outst--;
      end
      if (mem_if.read && mem_if.write) overlap++;
      if (mem_if.read || mem_if.write) strobes++;
      mem_if.waitrequest = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!mem_if.waitrequest) begin
        if (mem_if.read) begin
          e.due = cyc + lat;
          e.d   = mem[mem_if.address[11:2]];
          rq.push_back(e);
          rlog_a.push_back(mem_if.address);
          outst++;
          if (outst > max_outst) max_outst = outst;
        end else if (mem_if.write) begin
          mem[mem_if.address[11:2]] = mem_if.writedata;
          wlog_a.push_back(mem_if.address);
          wlog_d.push_back(mem_if.writedata);
        end
      end
    end
  end

  task automatic csr_xfer(input  logic        rd,
                          input  logic [3:0]  a,
                          input  logic [31:0] d,
                          output logic [31:0] q,
                          output int          waits);
    int n;
    n = 0;
    @(negedge clk);
    csr_if.read      = rd;
    csr_if.write     = !rd;
    csr_if.address   = a;
    csr_if.writedata = d;
    #1;
    while (csr_if.waitrequest && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("csr_timeout", csr_if.waitrequest, 0);
    q     = csr_if.readdata;
    waits = n;
    @(posedge clk);
    #1;
    csr_if.read  = 1'b0;
    csr_if.write = 1'b0;
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    int          w;
    csr_xfer(1'b0, a, d, q, w);
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] q);
    int w;
    csr_xfer(1'b1, a, 32'd0, q, w);
  endtask

  task automatic setup(input logic [31:0] dst, input logic [31:0] src,
                       input logic [31:0] num, input logic [31:0] ss,
                       input logic [31:0] ds);
    csr_wr(4'd1, dst);
    csr_wr(4'd2, src);
    csr_wr(4'd3, num);
    csr_wr(4'd4, ss);
    csr_wr(4'd5, ds);
  endtask

  initial begin
    logic [31:0] q;
    int          w;
    int          wb;
    int          rb;
    int          sb;

    csr_if.read      = 1'b0;
    csr_if.write     = 1'b0;
    csr_if.address   = '0;
    csr_if.writedata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mrd", mem_if.read, 0);
    chk("rst_mwr", mem_if.write, 0);
    chk("rst_addr", mem_if.address, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cwait", csr_if.waitrequest, 0);
    chk("rst_rdata", csr_if.readdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    csr_rd(4'd0, q);
    chk("rst_ctrl", q, 0);
    csr_rd(4'd3, q);
    chk("rst_num", q, 0);
    csr_rd(4'd9, q);
    chk("rst_unmapped", q, 0);

    // basic 4-word copy, CTRL read stalls until done
    lat = 1;
    rnd_wait = 1'b0;
    wb = wlog_a.size();
    setup(32'h200, 32'h100, 32'd4, 32'd4, 32'd4);
    csr_wr(4'd0, 32'h1);
    csr_xfer(1'b1, 4'd0, 32'd0, q, w);
    chk("a_ctrl", q, 32'h2);
    chk("a_stall", w > 4, 1);
    chk("a_nwr", wlog_a.size() - wb, 4);
    for (int i = 0; i < 4; i++)
      chk("a_mem", mem[128 + i], 32'hC0DE_0100 + 32'(4 * i));
    csr_rd(4'd6, q);
    chk("a_wdone", q, 4);
    chk("a_irq", irq, 0);

    // 20 words, random stalls, latency 6
    rnd_wait = 1'b1;
    lat = 6;
    setup(32'h600, 32'h300, 32'd20, 32'd4, 32'd4);
    csr_wr(4'd0, 32'h1);
    csr_wr(4'd1, 32'hF00);
    csr_rd(4'd0, q);
    chk("b_ctrl", q, 32'h2);
    for (int i = 0; i < 20; i++)
      chk("b_mem", mem[384 + i], 32'hC0DE_0300 + 32'(4 * i));
    csr_rd(4'd6, q);
    chk("b_wdone", q, 20);
    csr_rd(4'd1, q);
    chk("b_dst_kept", q, 32'h600);
    chk("b_max_outst", max_outst <= 8, 1);
    chk("b_overlap", overlap, 0);

    // gather with stride 8 into a fixed address
    rnd_wait = 1'b0;
    lat = 2;
    wb = wlog_a.size();
    rb = rlog_a.size();
    setup(32'h200, 32'h100, 32'd3, 32'd8, 32'd0);
    csr_wr(4'd0, 32'h1);
    csr_rd(4'd0, q);
    chk("c_ctrl", q, 32'h2);
    chk("c_nwr", wlog_a.size() - wb, 3);
    for (int i = 0; i < 3; i++) begin
      chk("c_waddr", wlog_a[wb + i], 32'h200);
      chk("c_wdata", wlog_d[wb + i], 32'hC0DE_0100 + 32'(8 * i));
      chk("c_raddr", rlog_a[rb + i], 32'h100 + 32'(8 * i));
    end

    // zero-length start with irq enabled
    sb = strobes;
    csr_wr(4'd3, 32'd0);
    csr_wr(4'd0, 32'h5);
    chk("d_irq", irq, 1);
    csr_rd(4'd0, q);
    chk("d_ctrl", q, 32'h2);
    chk("d_nostrobe", strobes - sb, 0);
    csr_wr(4'd0, 32'h8);
    chk("d_irq_clr", irq, 0);
    csr_rd(4'd0, q);
    chk("d_ctrl_clr", q, 0);

    // abort a long copy after a few writes
    lat = 2;
    wb = wlog_a.size();
    setup(32'hE00, 32'hA00, 32'd100, 32'd4, 32'd4);
    csr_wr(4'd0, 32'h1);
    for (int n = 0; n < 2000 && wlog_a.size() < wb + 5; n++)
      @(negedge clk);
    chk("e_5wr", wlog_a.size() - wb >= 5, 1);
    csr_wr(4'd0, 32'h2);
    csr_rd(4'd0, q);
    chk("e_ctrl", q, 32'h4);
    csr_rd(4'd6, q);
    chk("e_wdone", q, wlog_a.size() - wb);
    chk("e_range", (q >= 5) && (q < 100), 1);
    chk("e_outst", outst, 0);
    chk("e_rq", rq.size(), 0);

    // reset in the middle of a copy
    lat = 3;
    setup(32'hC00, 32'h300, 32'd20, 32'd4, 32'd4);
    csr_wr(4'd0, 32'h1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("f_mrd", mem_if.read, 0);
    chk("f_mwr", mem_if.write, 0);
    chk("f_addr", mem_if.address, 0);
    chk("f_wdata", mem_if.writedata, 0);
    chk("f_rdata", csr_if.readdata, 0);
    chk("f_irq", irq, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb = strobes;
    repeat (10) @(negedge clk);
    chk("f_nostrobe", strobes - sb, 0);
    csr_rd(4'd0, q);
    chk("f_ctrl", q, 0);
    csr_rd(4'd3, q);
    chk("f_num", q, 0);
    csr_rd(4'd6, q);
    chk("f_wdone", q, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
